// File: rtl/ctrl_pkg.sv
// Shared definitions for the multicycle control FSM: state encodings,
// opcode constants, ALU function codes, strobe vector layout and the
// default memory-wait timeout.
package ctrl_pkg;

    localparam int MEM_TIMEOUT_DEF = 16;
    localparam int TO_W_DEF        = 5;

    typedef enum logic [4:0] {
        S_FETCH0  = 5'd0,
        S_FETCH1  = 5'd1,
        S_DECODE  = 5'd2,
        S_ALU0    = 5'd3,
        S_ALU1    = 5'd4,
        S_LD0     = 5'd5,
        S_LD1     = 5'd6,
        S_LD2     = 5'd7,
        S_ST0     = 5'd8,
        S_ST1     = 5'd9,
        S_ST2     = 5'd10,
        S_J0      = 5'd11,
        S_PU0     = 5'd12,
        S_PU1     = 5'd13,
        S_PO0     = 5'd14,
        S_PO1     = 5'd15,
        S_PO2     = 5'd16,
        S_PO3     = 5'd17,
        S_CA0     = 5'd18,
        S_CA1     = 5'd19,
        S_CA2     = 5'd20,
        S_CA3     = 5'd21,
        S_RE0     = 5'd22,
        S_RE1     = 5'd23,
        S_RE2     = 5'd24,
        S_RE3     = 5'd25,
        S_HALT    = 5'd30,
        S_ILLEGAL = 5'd31
    } state_t;

    localparam logic [4:0] OP_LOAD  = 5'b01000;
    localparam logic [4:0] OP_STORE = 5'b01001;
    localparam logic [4:0] OP_JMP   = 5'b01010;
    localparam logic [4:0] OP_JZ    = 5'b01011;
    localparam logic [4:0] OP_PUSH  = 5'b01100;
    localparam logic [4:0] OP_POP   = 5'b01101;
    localparam logic [4:0] OP_CALL  = 5'b01110;
    localparam logic [4:0] OP_RET   = 5'b01111;
    localparam logic [4:0] OP_HALT  = 5'b11111;

    localparam logic [2:0] FN_ADD = 3'b000;
    localparam logic [2:0] FN_SUB = 3'b001;
    localparam logic [2:0] FN_AND = 3'b010;
    localparam logic [2:0] FN_OR  = 3'b011;
    localparam logic [2:0] FN_XOR = 3'b100;
    localparam logic [2:0] FN_NOT = 3'b101;
    localparam logic [2:0] FN_INC = 3'b110;
    localparam logic [2:0] FN_DEC = 3'b111;

    // fn_from_ir selects the ALU op from the instruction instead of fn_sel
    typedef struct packed {
        logic       ldmar;
        logic       ldir;
        logic       ldpc;
        logic       ldsp;
        logic       ldmdr;
        logic       ldreg;
        logic       ldregbank;
        logic       treg;
        logic       tregbank;
        logic       tsp;
        logic       tmar;
        logic       tpc;
        logic       tmdr;
        logic       tlabel;
        logic       memread;
        logic       memwrite;
        logic       irwrite;
        logic [2:0] fn_sel;
        logic       fn_from_ir;
    } strobe_t;

    // States that stall on mem_ready
    function automatic logic is_mem_state(input state_t s);
        logic r;
        case (s)
            S_FETCH1, S_LD1, S_ST2, S_PO1, S_CA3, S_RE1: r = 1'b1;
            default:                                     r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/ctrl_strobe_decode.sv
// Pure combinational state -> strobe ROM for the multicycle controller.
// Optional feature macro: STACK_OPS_EN (adds PUSH/POP/CALL/RET states).
module ctrl_strobe_decode
    import ctrl_pkg::*;
(
    input  state_t  state,
    output strobe_t strb
);

    // Moore strobe table; anything not listed drives nothing
    always_comb begin
        strb = '0;
        case (state)
            S_FETCH0: begin strb.tpc = 1'b1; strb.ldmar = 1'b1; end
            S_FETCH1: begin strb.memread = 1'b1; strb.irwrite = 1'b1; strb.ldir = 1'b1; end
            S_DECODE: begin strb.tpc = 1'b1; strb.fn_sel = FN_INC; strb.ldpc = 1'b1; end
            S_ALU0:   begin strb.tregbank = 1'b1; strb.ldreg = 1'b1; end
            S_ALU1:   begin strb.treg = 1'b1; strb.fn_from_ir = 1'b1; strb.ldregbank = 1'b1; end
            S_LD0:    begin strb.tlabel = 1'b1; strb.ldmar = 1'b1; end
            S_LD1:    begin strb.memread = 1'b1; strb.ldmdr = 1'b1; end
            S_LD2:    begin strb.tmdr = 1'b1; strb.ldregbank = 1'b1; end
            S_ST0:    begin strb.tlabel = 1'b1; strb.ldmar = 1'b1; end
            S_ST1:    begin strb.tregbank = 1'b1; strb.ldmdr = 1'b1; end
            S_ST2:    begin strb.memwrite = 1'b1; end
            S_J0:     begin strb.tlabel = 1'b1; strb.ldpc = 1'b1; end
`ifdef STACK_OPS_EN
            S_PU0:    begin strb.tsp = 1'b1; strb.fn_sel = FN_DEC; strb.ldsp = 1'b1; end
            S_PU1:    begin strb.tsp = 1'b1; strb.ldmar = 1'b1; end
            S_PO0:    begin strb.tsp = 1'b1; strb.ldmar = 1'b1; end
            S_PO1:    begin strb.memread = 1'b1; strb.ldmdr = 1'b1; end
            S_PO2:    begin strb.tmdr = 1'b1; strb.ldregbank = 1'b1; end
            S_PO3:    begin strb.tsp = 1'b1; strb.fn_sel = FN_INC; strb.ldsp = 1'b1; end
            S_CA0:    begin strb.tsp = 1'b1; strb.fn_sel = FN_DEC; strb.ldsp = 1'b1; end
            S_CA1:    begin strb.tsp = 1'b1; strb.ldmar = 1'b1; end
            S_CA2:    begin strb.tpc = 1'b1; strb.ldmdr = 1'b1; end
            S_CA3:    begin strb.memwrite = 1'b1; end
            S_RE0:    begin strb.tsp = 1'b1; strb.ldmar = 1'b1; end
            S_RE1:    begin strb.memread = 1'b1; strb.ldmdr = 1'b1; end
            S_RE2:    begin strb.tmdr = 1'b1; strb.ldpc = 1'b1; end
            S_RE3:    begin strb.tsp = 1'b1; strb.fn_sel = FN_INC; strb.ldsp = 1'b1; end
`endif
            default:  strb = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Hardwired multicycle control FSM for the 16-bit datapath, with a
// mem_ready wait handshake and a bus-error timeout on memory states.
// Optional feature macro: STACK_OPS_EN (PUSH/POP/CALL/RET sequences).
module multicycle_controller
    import ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF,
    parameter int TO_W        = TO_W_DEF
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [15:0] IR,
    input  logic        z,
    input  logic        mem_ready,
    output logic [4:0]  state,
    output logic [4:0]  nextstate,
    output logic [2:0]  fnSel,
    output logic        ldMAR,
    output logic        ldIR,
    output logic        ldPC,
    output logic        ldSP,
    output logic        ldMDR,
    output logic        ldReg,
    output logic        ldRegBank,
    output logic        TReg,
    output logic        TRegBank,
    output logic        TSP,
    output logic        TMAR,
    output logic        TPC,
    output logic        TMDR,
    output logic        TLabel,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        IRWrite,
    output logic        halted,
    output logic        bus_err
);

    state_t          state_r;
    state_t          seq_next_s;
    state_t          next_s;
    logic [TO_W-1:0] wait_cnt_r;
    logic [4:0]      opcode_s;
    logic            mem_state_s;
    logic            timeout_s;
    logic            out_en_s;
    strobe_t         strb_s;
    logic            ir_unused_s;

    assign opcode_s    = IR[15:11];
    assign mem_state_s = is_mem_state(state_r);
    assign timeout_s   = (wait_cnt_r == TO_W'(MEM_TIMEOUT));
    assign out_en_s    = ~Reset;
    assign ir_unused_s = ^IR[10:0];

    // Sequencing: where each state goes once its work (and any memory access) is done
    always_comb begin
        seq_next_s = S_ILLEGAL;
        case (state_r)
            S_FETCH0: seq_next_s = S_FETCH1;
            S_FETCH1: seq_next_s = S_DECODE;
            S_DECODE: begin
                if (opcode_s[4:3] == 2'b00) begin
                    seq_next_s = S_ALU0;
                end else begin
                    case (opcode_s)
                        OP_LOAD:  seq_next_s = S_LD0;
                        OP_STORE: seq_next_s = S_ST0;
                        OP_JMP:   seq_next_s = S_J0;
                        OP_JZ: begin
                            if (z) seq_next_s = S_J0;
                            else   seq_next_s = S_FETCH0;
                        end
`ifdef STACK_OPS_EN
                        OP_PUSH:  seq_next_s = S_PU0;
                        OP_POP:   seq_next_s = S_PO0;
                        OP_CALL:  seq_next_s = S_CA0;
                        OP_RET:   seq_next_s = S_RE0;
`endif
                        OP_HALT:  seq_next_s = S_HALT;
                        default:  seq_next_s = S_ILLEGAL;
                    endcase
                end
            end
            S_ALU0:    seq_next_s = S_ALU1;
            S_ALU1:    seq_next_s = S_FETCH0;
            S_LD0:     seq_next_s = S_LD1;
            S_LD1:     seq_next_s = S_LD2;
            S_LD2:     seq_next_s = S_FETCH0;
            S_ST0:     seq_next_s = S_ST1;
            S_ST1:     seq_next_s = S_ST2;
            S_ST2:     seq_next_s = S_FETCH0;
            S_J0:      seq_next_s = S_FETCH0;
`ifdef STACK_OPS_EN
            S_PU0:     seq_next_s = S_PU1;
            S_PU1:     seq_next_s = S_ST1;
            S_PO0:     seq_next_s = S_PO1;
            S_PO1:     seq_next_s = S_PO2;
            S_PO2:     seq_next_s = S_PO3;
            S_PO3:     seq_next_s = S_FETCH0;
            S_CA0:     seq_next_s = S_CA1;
            S_CA1:     seq_next_s = S_CA2;
            S_CA2:     seq_next_s = S_CA3;
            S_CA3:     seq_next_s = S_J0;
            S_RE0:     seq_next_s = S_RE1;
            S_RE1:     seq_next_s = S_RE2;
            S_RE2:     seq_next_s = S_RE3;
            S_RE3:     seq_next_s = S_FETCH0;
`endif
            S_HALT:    seq_next_s = S_HALT;
            S_ILLEGAL: seq_next_s = S_ILLEGAL;
            default:   seq_next_s = S_ILLEGAL;
        endcase
    end

    // Memory stall and timeout override; mem_ready at the limit still advances
    always_comb begin
        next_s = seq_next_s;
        if (Reset) begin
            next_s = S_FETCH0;
        end else if (mem_state_s && !mem_ready) begin
            if (timeout_s) next_s = S_ILLEGAL;
            else           next_s = state_r;
        end else begin
            next_s = seq_next_s;
        end
    end

    // State register
    always_ff @(posedge Clk) begin
        if (Reset) state_r <= S_FETCH0;
        else       state_r <= next_s;
    end

    // Wait-cycle counter: counts stalled cycles in a memory state, clears on exit
    always_ff @(posedge Clk) begin
        if (Reset)
            wait_cnt_r <= {TO_W{1'b0}};
        else if (mem_state_s && !mem_ready && !timeout_s)
            wait_cnt_r <= wait_cnt_r + {{(TO_W-1){1'b0}}, 1'b1};
        else
            wait_cnt_r <= {TO_W{1'b0}};
    end

    ctrl_strobe_decode u_decode (
        .state (state_r),
        .strb  (strb_s)
    );

    assign state     = state_r;
    assign nextstate = next_s;

    assign fnSel     = (strb_s.fn_from_ir ? IR[13:11] : strb_s.fn_sel) & {3{out_en_s}};
    assign ldMAR     = strb_s.ldmar     & out_en_s;
    assign ldIR      = strb_s.ldir      & out_en_s;
    assign ldPC      = strb_s.ldpc      & out_en_s;
    assign ldMDR     = strb_s.ldmdr     & out_en_s;
    assign ldReg     = strb_s.ldreg     & out_en_s;
    assign ldRegBank = strb_s.ldregbank & out_en_s;
    assign TReg      = strb_s.treg      & out_en_s;
    assign TRegBank  = strb_s.tregbank  & out_en_s;
    assign TMAR      = strb_s.tmar      & out_en_s;
    assign TPC       = strb_s.tpc       & out_en_s;
    assign TMDR      = strb_s.tmdr      & out_en_s;
    assign TLabel    = strb_s.tlabel    & out_en_s;
    assign MemRead   = strb_s.memread   & out_en_s;
    assign MemWrite  = strb_s.memwrite  & out_en_s;
    assign IRWrite   = strb_s.irwrite   & out_en_s;
    assign halted    = (state_r == S_HALT)    & out_en_s;
    assign bus_err   = (state_r == S_ILLEGAL) & out_en_s;

`ifdef STACK_OPS_EN
    assign ldSP = strb_s.ldsp & out_en_s;
    assign TSP  = strb_s.tsp  & out_en_s;
`else
    logic stack_unused_s;
    assign stack_unused_s = strb_s.ldsp ^ strb_s.tsp;
    assign ldSP = 1'b0;
    assign TSP  = 1'b0;
`endif

endmodule
